// File: rtl/keypad_scanner.sv
// Matrix keypad front end: column strobing, 2-flop row synchronisation,
// whole-image debounce across full scans, and n-key-lockout press events.
module keypad_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int DEBOUNCE_SCANS = 3,
  localparam int N             = ROWS * COLS,
  localparam int CODE_W        = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROWS-1:0]   row_n,
  output logic [COLS-1:0]   col_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ack,
  output logic              key_pressed,
  output logic              key_release,
  output logic              overrun,
  output logic [1:0]        dbg_state
);

  localparam int COL_W = $clog2(COLS);
  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam int ST_W  = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    SAMPLE = 2'd1,
    EVAL   = 2'd2
  } state_t;

  state_t                     state;
  logic                       run;
  logic [COL_W-1:0]           col;
  logic [CNT_W-1:0]           cnt;
  logic [ROWS-1:0]            sync1;
  logic [ROWS-1:0]            sync2;
  logic [COLS-1:0][ROWS-1:0]  scan;
  logic [COLS-1:0][ROWS-1:0]  prev;
  logic [COLS-1:0][ROWS-1:0]  debounced;
  logic [ST_W-1:0]            stable;
  logic [ST_W-1:0]            stable_nx;
  logic                       commit;
  logic                       press_ev;
  logic                       release_ev;

  assign dbg_state = state;

  function automatic logic [CODE_W-1:0] lowest_index(input logic [N-1:0] v);
    lowest_index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) lowest_index = CODE_W'(i);
    end
  endfunction

  always_comb begin
    stable_nx = ST_W'(1);
    if (scan == prev) begin
      stable_nx = (stable == ST_W'(DEBOUNCE_SCANS)) ? stable : stable + ST_W'(1);
    end
    commit     = (state == EVAL) && (stable_nx == ST_W'(DEBOUNCE_SCANS)) && (scan != debounced);
    press_ev   = commit && (debounced == '0);
    release_ev = commit && (scan == '0);
  end

  // key_valid/key_ack: key_valid rises on a committed press and holds until a
  // cycle with key_ack high; an ack coinciding with a new press loses to the press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SETTLE;
      run         <= 1'b0;
      col         <= '0;
      cnt         <= '0;
      col_n       <= '1;
      sync1       <= '1;
      sync2       <= '1;
      scan        <= '0;
      prev        <= '0;
      debounced   <= '0;
      stable      <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
      key_release <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sync1       <= row_n;
      sync2       <= sync1;
      key_release <= 1'b0;
      if (key_ack && key_valid) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
      end
      // The first post-reset edge only starts the scan so column 0 gets a full settle window.
      if (!run) begin
        run   <= 1'b1;
        col_n <= ~COLS'(1);
      end else begin
        case (state)
          SETTLE: begin
            if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
              cnt   <= '0;
              state <= SAMPLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          SAMPLE: begin
            scan[col] <= ~sync2;
            if (col == COL_W'(COLS - 1)) begin
              col_n <= '1;
              state <= EVAL;
            end else begin
              col   <= col + COL_W'(1);
              col_n <= ~(COLS'(1) << (col + COL_W'(1)));
              state <= SETTLE;
            end
          end
          EVAL: begin
            stable <= stable_nx;
            prev   <= scan;
            if (commit) begin
              debounced <= scan;
              if (press_ev) begin
                key_code    <= lowest_index(scan);
                key_pressed <= 1'b1;
                key_valid   <= 1'b1;
                if (key_valid && !key_ack) overrun <= 1'b1;
              end
              if (release_ev) begin
                key_pressed <= 1'b0;
                key_release <= 1'b1;
              end
            end
            col   <= '0;
            col_n <= ~COLS'(1);
            state <= SETTLE;
          end
          default: state <= SETTLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a scan-level keypad model predicts every output
// each cycle, and directed scenarios pin hand-computed values.
module tb_keypad_scanner;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int SETTLE = 8;
  localparam int DEB    = 3;
  localparam int N      = ROWS * COLS;
  localparam int CODE_W = 4;
  localparam int COLT   = SETTLE + 1;
  localparam int PERIOD = COLS * COLT + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              key_ack = 1'b0;
  logic [ROWS-1:0]   row_n;
  logic [COLS-1:0]   col_n;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_pressed;
  logic              key_release;
  logic              overrun;
  logic [1:0]        dbg_state;
  logic [N-1:0]      held = '0;

  int n_checks = 0;
  int n_errors = 0;
  int rel_seen = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
    .key_pressed(key_pressed), .key_release(key_release),
    .overrun(overrun), .dbg_state(dbg_state)
  );

  // Physical keypad: a held key shorts its row to its column strobe.
  always_comb begin
    row_n = '1;
    for (int c = 0; c < COLS; c++) begin
      if (col_n[c] == 1'b0) begin
        for (int r = 0; r < ROWS; r++) begin
          if (held[c*ROWS+r]) row_n[r] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic              m_init = 1'b0;
  int                m_phase = -1;
  logic [N-1:0]      m_img;
  logic [N-1:0]      m_deb;
  logic [N-1:0]      scan_q[$];
  logic              m_valid, m_pressed, m_release, m_over;
  logic [CODE_W-1:0] m_code;
  logic              m_old_valid;
  int                m_col;

  function automatic logic [CODE_W-1:0] first_key(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return CODE_W'(i);
    return '0;
  endfunction

  function automatic logic [COLS-1:0] exp_col(input int phase);
    logic [COLS-1:0] one;
    one = COLS'(1);
    if (phase < 0 || phase == PERIOD - 1) return '1;
    return ~(one << (phase / COLT));
  endfunction

  task automatic end_of_scan(input logic old_valid, input logic ack);
    logic steady;
    scan_q.push_back(m_img);
    if (scan_q.size() > DEB) void'(scan_q.pop_front());
    steady = (scan_q.size() == DEB);
    foreach (scan_q[i]) if (scan_q[i] != m_img) steady = 1'b0;
    if (steady && m_img != m_deb) begin
      if (m_deb == '0) begin
        m_code    = first_key(m_img);
        m_pressed = 1'b1;
        if (old_valid && !ack) m_over = 1'b1;
        m_valid   = 1'b1;
      end else if (m_img == '0) begin
        m_pressed = 1'b0;
        m_release = 1'b1;
      end
      m_deb = m_img;
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_init = 1'b1; m_phase = -1; m_img = '0; m_deb = '0; scan_q.delete();
      m_valid = 0; m_pressed = 0; m_release = 0; m_over = 0; m_code = '0;
    end else if (m_init) begin
      m_release   = 1'b0;
      m_old_valid = m_valid;
      if (key_ack && m_valid) begin
        m_valid = 1'b0;
        m_over  = 1'b0;
      end
      if (m_phase >= 0 && m_phase < PERIOD - 1 && (m_phase % COLT) == SETTLE) begin
        m_col = m_phase / COLT;
        m_img[m_col*ROWS +: ROWS] = held[m_col*ROWS +: ROWS];
      end
      if (m_phase == PERIOD - 1) end_of_scan(m_old_valid, key_ack);
      m_phase = (m_phase < 0) ? 0 : (m_phase + 1) % PERIOD;
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (m_init) begin
      check("col_n", col_n, exp_col(m_phase));
      check("key_valid", key_valid, m_valid);
      check("key_code", key_code, m_code);
      check("key_pressed", key_pressed, m_pressed);
      check("key_release", key_release, m_release);
      check("overrun", overrun, m_over);
      check("dbg_eval", dbg_state == 2'd2, m_phase == PERIOD - 1);
      if (key_release === 1'b1) rel_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_eval();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_phase != PERIOD - 1 && n < 200);
    check("scan_timeout", m_phase, PERIOD - 1);
  endtask

  // Present a key image for one full scan; ends just after that scan's EVAL edge.
  task automatic scan_with(input logic [N-1:0] k, input logic ack_at_eval);
    held = k;
    wait_eval();
    if (ack_at_eval) key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [CODE_W-1:0] code,
                            input logic p, input logic rel, input logic ov);
    check({tag, "_valid"}, key_valid, v);
    check({tag, "_code"}, key_code, code);
    check({tag, "_pressed"}, key_pressed, p);
    check({tag, "_release"}, key_release, rel);
    check({tag, "_overrun"}, overrun, ov);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    // 1: idle scanning, column sequence and period
    do_reset();
    check("t1_col_idle", col_n, 4'b1111);
    expect_out("t1_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t1_col0", col_n, 4'b1110);
    n = 0;
    while (col_n != 4'b1111 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t1_low_cycles", n, 36);
    @(negedge clk);
    check("t1_wrap", col_n, 4'b1110);
    scan_with(16'h0000, 0);
    scan_with(16'h0000, 0);
    expect_out("t1_idle", 0, 0, 0, 0, 0);

    // 2: key col2/row1 -> code 9 after three scans
    do_reset();
    scan_with(16'h0200, 0);
    scan_with(16'h0200, 0);
    expect_out("t2_scan2", 0, 0, 0, 0, 0);
    scan_with(16'h0200, 0);
    expect_out("t2_commit", 1, 9, 1, 0, 0);
    ack_pulse();
    expect_out("t2_ack", 0, 9, 1, 0, 0);

    // 3: bounce delays the commit to scan 5; release after four stable scans
    do_reset();
    scan_with(16'h0040, 0);
    scan_with(16'h0000, 0);
    scan_with(16'h0040, 0);
    scan_with(16'h0040, 0);
    expect_out("t3_scan4", 0, 0, 0, 0, 0);
    scan_with(16'h0040, 0);
    expect_out("t3_commit", 1, 6, 1, 0, 0);
    ack_pulse();
    scan_with(16'h0040, 0);
    scan_with(16'h0000, 0);
    scan_with(16'h0000, 0);
    expect_out("t3_rel2", 0, 6, 1, 0, 0);
    scan_with(16'h0000, 0);
    expect_out("t3_release", 0, 6, 0, 1, 0);
    @(negedge clk);
    check("t3_release_pulse", key_release, 1'b0);

    // 4: second press without ack -> overrun
    do_reset();
    repeat (3) scan_with(16'h0001, 0);
    expect_out("t4_first", 1, 0, 1, 0, 0);
    repeat (3) scan_with(16'h0000, 0);
    expect_out("t4_release", 1, 0, 0, 1, 0);
    repeat (3) scan_with(16'h8000, 0);
    expect_out("t4_overrun", 1, 15, 1, 0, 1);
    ack_pulse();
    expect_out("t4_ack", 0, 15, 1, 0, 0);

    // 5: n-key lockout
    do_reset();
    rel_seen = 0;
    repeat (3) scan_with(16'h0020, 0);
    expect_out("t5_press", 1, 5, 1, 0, 0);
    ack_pulse();
    repeat (3) scan_with(16'h0420, 0);
    expect_out("t5_lockout", 0, 5, 1, 0, 0);
    repeat (3) scan_with(16'h0000, 0);
    expect_out("t5_release", 0, 5, 0, 1, 0);
    repeat (40) @(negedge clk);
    check("t5_release_count", rel_seen, 1);

    // 6: reset mid-debounce, then ack coinciding with a press commit
    do_reset();
    repeat (3) scan_with(16'h0008, 0);
    expect_out("t6_press", 1, 3, 1, 0, 0);
    repeat (2) scan_with(16'h0000, 0);
    repeat (10) @(negedge clk);
    do_reset();
    check("t6_col_reset", col_n, 4'b1111);
    expect_out("t6_reset", 0, 0, 0, 0, 0);
    repeat (2) scan_with(16'h1000, 0);
    expect_out("t6_recount", 0, 0, 0, 0, 0);
    scan_with(16'h1000, 1);
    expect_out("t6_ack_idle", 1, 12, 1, 0, 0);
    repeat (3) scan_with(16'h0000, 0);
    expect_out("t6_release", 1, 12, 0, 1, 0);
    repeat (2) scan_with(16'h0008, 0);
    scan_with(16'h0008, 1);
    expect_out("t6_press_wins", 1, 3, 1, 0, 0);
    ack_pulse();
    expect_out("t6_final_ack", 0, 3, 1, 0, 0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Matrix keypad front end. Drives the column strobes of a ROWS x COLS keypad one column at a time and samples the row returns through a 2-flop synchronizer. It debounces the whole key image across consecutive full scans and presents press events through a valid/ack register pair to the wishbone keypad peripheral. Single-key operation uses n-key lockout.

Parameters:
ROWS, 4, number of row inputs (2..8)
COLS, 4, number of column outputs (2..8)
SETTLE_CYCLES, 8, cycles a column is held low before sampling; must be >= 3 to cover the 2-flop sync
DEBOUNCE_SCANS, 3, consecutive identical full scans required before the image is committed (>= 2)
Derived: N = ROWS*COLS; CODE_W = clog2(N)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active low
row_n  input  ROWS  asynchronous row returns, active low, externally pulled up
col_n  output  COLS  column strobes, active low, at most one bit low
key_code  output  CODE_W  index of pressed key = col*ROWS + row
key_valid  output  1  press event pending; held until key_ack
key_ack  input  1  consumer acknowledge; one-cycle pulse
key_pressed  output  1  level: a debounced key is currently held
key_release  output  1  one-cycle pulse on debounced release
overrun  output  1  sticky: a press was committed while key_valid was still set

Behaviour:
- Reset (rst_n low at a clk edge) sets: col_n all 1, key_code 0, key_valid 0, key_pressed 0, key_release 0, overrun 0, sync flops all 1, scan/prev/debounced images 0, stable count 0, column index 0, FSM in SETTLE. Reset mid-scan aborts the scan; nothing is committed.
- FSM states:
  - SETTLE: col_n has bit[col] low. Counter runs 0..SETTLE_CYCLES-1.
  - SAMPLE: 1 cycle. scan[col*ROWS+r] <= ~row_sync[r]. If col == COLS-1, go to EVAL; otherwise col+1 and back to SETTLE.
  - EVAL: 1 cycle, col_n all 1. Debounce update, then col <= 0 and back to SETTLE.
- Each column takes SETTLE_CYCLES+1 cycles. Scan period = COLS*(SETTLE_CYCLES+1)+1 cycles, 37 at the defaults.
- First column drives low in the first cycle after rst_n deasserts.
- Debounce, done in EVAL:
  - If scan == prev, stable count increments, saturating at DEBOUNCE_SCANS. Otherwise stable count = 1 and prev <= scan.
  - A commit happens when stable count becomes DEBOUNCE_SCANS and scan != debounced. Then debounced <= scan.
  - Net effect: a change is committed at the EVAL of the DEBOUNCE_SCANS-th consecutive identical scan.
- Events, evaluated on commit only:
  - Zero to nonzero (press): key_code <= lowest set index, key_pressed <= 1, key_valid <= 1. If key_valid was already 1 and key_ack is not present this cycle, overrun <= 1 and key_code is overwritten with the new code.
  - Nonzero to zero (release): key_pressed <= 0, key_release = 1 for exactly one cycle. key_valid and key_code are unchanged.
  - Nonzero to different nonzero (lockout): no event. key_pressed stays 1 and key_code is unchanged.
- Handshake:
  - key_ack while key_valid = 1: key_valid <= 0 and overrun <= 0 on the next edge.
  - key_ack while key_valid = 0: ignored.
  - key_ack in the same cycle as a press commit: the press wins. key_valid stays 1 with the new key_code and no overrun is set.
- Outputs are registered. key_valid, key_code and key_pressed update on the edge that ends EVAL.
- Never more than one col_n bit low. All bits are high during EVAL and during reset.

Test Plan:
1. Reset, then hold all row_n = 1. Observe col_n cycling 1110,1101,1011,0111 (9 cycles each), then 1111 for 1 cycle, with a 37-cycle period -> key_valid, key_pressed and overrun stay 0 throughout.
2. Key col2/row1 held low (row_n[1] = 0 only while col_n[2] = 0) from before scan 1 -> key_valid = 1 and key_code = 9 at the end of the 3rd scan's EVAL, key_pressed = 1. Pulse key_ack -> key_valid = 0 next cycle.
3. Bounce: key present in scans 1 and 3, absent in scan 2, then steady -> commit at the EVAL of scan 5, not earlier. Release after 4 stable scans -> key_release pulses exactly 1 cycle at the 3rd empty scan's EVAL and key_pressed falls.
4. Press key 0 and do not ack. Release it, then press key 15 -> after the second commit, key_code = 15, key_valid = 1, overrun = 1. key_ack clears both.
5. Hold key 5, then add key 10 -> no new event, key_code stays 5. Release both -> a single key_release pulse.
6. Assert rst_n low for 1 cycle mid-scan during a debounce count of 2 -> all outputs return to reset values and a fresh 3-scan count is needed before commit. Also drive key_ack in the commit cycle -> key_valid stays 1 and overrun = 0.
